// File: rtl/ball_motion_sched_if.sv
// ball_motion_sched_if: collision strobe in, ball motion controls out (BALL_SCHED_PAUSE_EN adds pause)
interface ball_motion_sched_if;
    logic       game_start;
    logic [2:0] collision;
    logic       col_valid;
`ifdef BALL_SCHED_PAUSE_EN
    logic       pause;
`endif
    logic [9:0] ball_speed;
    logic       step;
    logic       dir_x;
    logic       dir_y;
    logic       ball_reset;
    logic       score_l;
    logic       score_r;
    logic [1:0] state;

`ifdef BALL_SCHED_PAUSE_EN
    modport master (
        output game_start, collision, col_valid, pause,
        input  ball_speed, step, dir_x, dir_y, ball_reset, score_l, score_r, state
    );
    modport slave (
        input  game_start, collision, col_valid, pause,
        output ball_speed, step, dir_x, dir_y, ball_reset, score_l, score_r, state
    );
`else
    modport master (
        output game_start, collision, col_valid,
        input  ball_speed, step, dir_x, dir_y, ball_reset, score_l, score_r, state
    );
    modport slave (
        input  game_start, collision, col_valid,
        output ball_speed, step, dir_x, dir_y, ball_reset, score_l, score_r, state
    );
`endif
endinterface

// File: rtl/ball_motion_sched.sv
// ball_motion_sched: Pong serve/play/score sequencer with phase-accumulator stepping (BALL_SCHED_PAUSE_EN adds pause)
module ball_motion_sched #(
    parameter int SPEED_INIT  = 10,
    parameter int SPEED_INC   = 1,
    parameter int SPEED_MAX   = 40,
    parameter int STEP_THRESH = 1000000,
    parameter int ACC_W       = 21,
    parameter int SERVE_DELAY = 50000000,
    parameter int SCORE_HOLD  = 100000000
) (
    input logic                clk_100MHz,
    input logic                Reset,
    ball_motion_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, SERVE = 2'b01, PLAY = 2'b10, SCORE = 2'b11} state_t;

    localparam int TMAX = SERVE_DELAY > SCORE_HOLD ? SERVE_DELAY : SCORE_HOLD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [ACC_W:0]  THR       = (ACC_W + 1)'(STEP_THRESH);
    localparam logic [10:0]     MAX11     = 11'(SPEED_MAX);
    localparam logic [10:0]     INC11     = 11'(SPEED_INC);
    localparam logic [9:0]      INIT10    = 10'(SPEED_INIT);
    localparam logic [TW-1:0]   SERVE_END = TW'(SERVE_DELAY - 1);
    localparam logic [TW-1:0]   SCORE_END = TW'(SCORE_HOLD - 1);

    state_t           state;
    logic [9:0]       speed;
    logic [ACC_W-1:0] acc;
    logic [TW-1:0]    timer;
    logic             dir_x, dir_y, serve_dir;
    logic             step, ball_reset, score_l, score_r;
    logic [ACC_W:0]   sum;
    logic             hit;
    logic [10:0]      inc;
    logic [9:0]       speed_up;
    logic             frozen;

`ifdef BALL_SCHED_PAUSE_EN
    assign frozen = bus.pause;
`else
    assign frozen = 1'b0;
`endif

    // accumulator sum and saturated paddle-hit speed
    always_comb begin
        sum      = {1'b0, acc} + (ACC_W + 1)'(speed);
        hit      = sum >= THR;
        inc      = {1'b0, speed} + INC11;
        speed_up = inc > MAX11 ? MAX11[9:0] : inc[9:0];
    end

    // serve -> play -> score loop; pulses are registered and last one cycle
    always_ff @(posedge clk_100MHz) begin
        if (Reset) begin
            state      <= IDLE;
            speed      <= INIT10;
            acc        <= '0;
            timer      <= '0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b0;
            serve_dir  <= 1'b1;
            step       <= 1'b0;
            ball_reset <= 1'b0;
            score_l    <= 1'b0;
            score_r    <= 1'b0;
        end else begin
            step       <= 1'b0;
            ball_reset <= 1'b0;
            score_l    <= 1'b0;
            score_r    <= 1'b0;
            if (!bus.game_start) begin
                state <= IDLE;
                speed <= INIT10;
                acc   <= '0;
                timer <= '0;
            end else if (!frozen) begin
                case (state)
                    IDLE: begin
                        state      <= SERVE;
                        ball_reset <= 1'b1;
                        dir_x      <= serve_dir;
                        dir_y      <= 1'b0;
                        speed      <= INIT10;
                        acc        <= '0;
                        timer      <= '0;
                    end
                    SERVE: begin
                        timer <= timer == SERVE_END ? '0 : timer + 1'b1;
                        if (timer == SERVE_END) state <= PLAY;
                    end
                    PLAY: begin
                        acc  <= hit ? ACC_W'(sum - THR) : sum[ACC_W-1:0];
                        step <= hit;
                        if (bus.col_valid && bus.collision[2]) begin
                            state     <= SCORE;
                            timer     <= '0;
                            score_l   <= dir_x;
                            score_r   <= !dir_x;
                            serve_dir <= dir_x;
                        end else if (bus.col_valid) begin
                            if (bus.collision[0]) begin
                                dir_x <= !dir_x;
                                speed <= speed_up;
                            end
                            if (bus.collision[1]) dir_y <= !dir_y;
                        end
                    end
                    SCORE: begin
                        acc <= '0;
                        if (timer == SCORE_END) begin
                            state      <= SERVE;
                            ball_reset <= 1'b1;
                            dir_x      <= serve_dir;
                            dir_y      <= 1'b0;
                            speed      <= INIT10;
                            timer      <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.ball_speed = speed;
    assign bus.step       = step;
    assign bus.dir_x      = dir_x;
    assign bus.dir_y      = dir_y;
    assign bus.ball_reset = ball_reset;
    assign bus.score_l    = score_l;
    assign bus.score_r    = score_r;
    assign bus.state      = state;
endmodule

// File: tb/tb_ball_motion_sched.sv
// tb_ball_motion_sched: directed then random stimulus against a distance-based reference model
module tb_ball_motion_sched;
    localparam int THR = 100, INIT = 10, INC = 1, MAXS = 12, SD = 4, SH = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ball_motion_sched_if bus();

    ball_motion_sched #(
        .SPEED_INIT(INIT), .SPEED_INC(INC), .SPEED_MAX(MAXS), .STEP_THRESH(THR),
        .ACC_W(21), .SERVE_DELAY(SD), .SCORE_HOLD(SH)
    ) dut (
        .clk_100MHz(clk),
        .Reset(rst),
        .bus(bus)
    );

    int n_vec = 0, n_bad = 0;
    int m_state, m_speed, m_dist, m_timer;
    bit m_dx, m_dy, m_sd, m_step, m_br, m_sl, m_sr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(bus.state), m_state);
        chk("ball_speed", 32'(bus.ball_speed), m_speed);
        chk("step", 32'(bus.step), 32'(m_step));
        chk("dir_x", 32'(bus.dir_x), 32'(m_dx));
        chk("dir_y", 32'(bus.dir_y), 32'(m_dy));
        chk("ball_reset", 32'(bus.ball_reset), 32'(m_br));
        chk("score_l", 32'(bus.score_l), 32'(m_sl));
        chk("score_r", 32'(bus.score_r), 32'(m_sr));
    endtask

    task automatic serve();
        m_state = 1; m_br = 1; m_dx = m_sd; m_dy = 0;
        m_speed = INIT; m_dist = 0; m_timer = 0;
    endtask

    // reference: ball travel is the running sum of speed; a step is due whenever that
    // running distance crosses another multiple of the threshold
    task automatic model_tick(input bit r, input bit gs, input bit cv, input bit [2:0] col, input bit p);
        m_step = 0; m_br = 0; m_sl = 0; m_sr = 0;
        if (r) begin
            m_state = 0; m_speed = INIT; m_dist = 0; m_timer = 0;
            m_dx = 1; m_dy = 0; m_sd = 1;
        end else if (!gs) begin
            m_state = 0; m_speed = INIT; m_dist = 0; m_timer = 0;
        end else if (!p) begin
            if (m_state == 0) serve();
            else if (m_state == 1) begin
                if (m_timer == SD - 1) begin m_state = 2; m_timer = 0; end
                else m_timer++;
            end else if (m_state == 2) begin
                m_step = (m_dist + m_speed) / THR > m_dist / THR;
                m_dist += m_speed;
                if (cv && col[2]) begin
                    m_state = 3; m_timer = 0;
                    m_sl = m_dx; m_sr = !m_dx; m_sd = m_dx;
                end else if (cv) begin
                    if (col[0]) begin
                        m_dx = !m_dx;
                        m_speed = m_speed + INC > MAXS ? MAXS : m_speed + INC;
                    end
                    if (col[1]) m_dy = !m_dy;
                end
            end else begin
                m_dist = 0;
                if (m_timer == SH - 1) serve();
                else m_timer++;
            end
        end
    endtask

    logic [2:0] dlist [6] = '{3'b001, 3'b001, 3'b001, 3'b011, 3'b101, 3'b001};

    task automatic drive(input bit r, input bit gs, input bit cv, input bit [2:0] col, input bit p);
        rst            = r;
        bus.game_start = gs;
        bus.col_valid  = cv;
        bus.collision  = col;
`ifdef BALL_SCHED_PAUSE_EN
        bus.pause      = p;
`endif
        model_tick(r, gs, cv, col, p);
    endtask

    initial begin
        int dq, gap, pz_left;
        bit pz_done, r, gs, cv, p;
        bit [2:0] col;
        dq = 0; gap = 0; pz_left = 0; pz_done = 0;
        drive(1, 0, 0, 3'b000, 0);
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(negedge clk);
            check_all();
            r = 0; gs = 1; cv = 0; col = 3'b000; p = 0;
            if (cyc < 2) r = 1;
            else if (dq < 6) begin
                if (m_state == 2) gap++;
                if (m_state == 2 && gap >= 25) begin
                    cv = 1; col = dlist[dq]; gs = dq != 5; dq++; gap = 0;
                end
            end
`ifdef BALL_SCHED_PAUSE_EN
            else if (!pz_done) begin
                if (pz_left > 0) begin
                    p = 1; pz_left--;
                    if (pz_left == 0) pz_done = 1;
                end else if (m_state == 2 && m_dist % THR == 50) begin
                    p = 1; pz_left = 19;
                end
            end
`endif
            else begin
                r   = $urandom_range(0, 399) == 0;
                gs  = $urandom_range(0, 79) != 0;
                cv  = $urandom_range(0, 4) == 0;
                col = 3'($urandom);
`ifdef BALL_SCHED_PAUSE_EN
                p   = $urandom_range(0, 7) == 0;
`endif
            end
            drive(r, gs, cv, col, p);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
